// File: rtl/data_reg_arbiter_if.sv
// Per-requester access port to the shared data register file.
// The master side is the requester; the slave side is the arbiter.
interface data_reg_arbiter_if #(
   parameter int AW = 4,
   parameter int DW = 16
);
   logic          req;
   logic          we;
   logic          lock;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/data_reg_arbiter.sv
// Round-robin arbiter with a bounded lock that shares the data register file
// between the CPU execute stage (p0) and the loader (p1).
//
// state   | meaning
// OWN_P0  | port 0 held the most recent grant
// OWN_P1  | port 1 held the most recent grant (reset, so port 0 wins the first tie)
module data_reg_arbiter #(
   parameter int AW       = 4,
   parameter int DW       = 16,
   parameter int MAX_LOCK = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   data_reg_arbiter_if.slave    p0,
   data_reg_arbiter_if.slave    p1,
   output logic                 o_load_data,
   output logic [AW-1:0]        o_load_data_address,
   output logic [DW-1:0]        o_data_input,
   output logic [AW-1:0]        o_address,
   input  logic [DW-1:0]        i_data
);
   typedef enum logic {OWN_P0 = 1'b0, OWN_P1 = 1'b1} owner_t;

   localparam logic [3:0] LOCK_LIM = 4'(MAX_LOCK);

   owner_t        r_last;
   owner_t        w_last_nxt;
   logic          r_locked;
   logic          r_gnt_prev;
   logic [3:0]    r_lock_cnt;
   logic          w_gnt0;
   logic          w_gnt1;
   logic          w_any;
   logic          w_lock_hold;
   logic          w_sel_we;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_wdata;
   logic          w_rd0;
   logic          w_rd1;

   // r_locked already implies the last owner had req, lock and gnt last cycle
   assign w_lock_hold = r_locked && (r_lock_cnt < LOCK_LIM);

   always_comb begin
      w_gnt0     = 1'b0;
      w_gnt1     = 1'b0;
      w_last_nxt = r_last;
      if (rst_n) begin
         if (p0.req && p1.req) begin
            if (w_lock_hold) begin
               w_gnt0 = (r_last == OWN_P0);
               w_gnt1 = (r_last == OWN_P1);
            end else begin
               w_gnt0 = (r_last == OWN_P1);
               w_gnt1 = (r_last == OWN_P0);
            end
         end else if (p0.req) begin
            w_gnt0 = 1'b1;
         end else if (p1.req) begin
            w_gnt1 = 1'b1;
         end
      end
      if (w_gnt0) begin
         w_last_nxt = OWN_P0;
      end else if (w_gnt1) begin
         w_last_nxt = OWN_P1;
      end
   end

   assign w_any       = w_gnt0 | w_gnt1;
   assign w_sel_we    = w_gnt1 ? p1.we    : p0.we;
   assign w_sel_addr  = w_gnt1 ? p1.addr  : p0.addr;
   assign w_sel_wdata = w_gnt1 ? p1.wdata : p0.wdata;
   assign w_rd0       = w_gnt0 & ~p0.we;
   assign w_rd1       = w_gnt1 & ~p1.we;

   assign p0.gnt              = w_gnt0;
   assign p1.gnt              = w_gnt1;
   assign o_load_data         = w_any & w_sel_we;
   assign o_load_data_address = o_load_data ? w_sel_addr  : '0;
   assign o_data_input        = o_load_data ? w_sel_wdata : '0;
   assign o_address           = (w_any & ~w_sel_we) ? w_sel_addr : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last     <= OWN_P1;
         r_locked   <= 1'b0;
         r_gnt_prev <= 1'b0;
         r_lock_cnt <= 4'd0;
      end else begin
         r_last     <= w_last_nxt;
         r_gnt_prev <= w_any;
         r_locked   <= w_gnt0 ? p0.lock : (w_gnt1 ? p1.lock : 1'b0);
         if (w_any) begin
            if (r_gnt_prev && (w_last_nxt == r_last)) begin
               r_lock_cnt <= (r_lock_cnt == 4'hF) ? 4'hF : r_lock_cnt + 4'd1;
            end else begin
               r_lock_cnt <= 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0.rvalid <= 1'b0;
         p1.rvalid <= 1'b0;
         p0.rdata  <= '0;
         p1.rdata  <= '0;
      end else begin
         p0.rvalid <= w_rd0;
         p1.rvalid <= w_rd1;
         if (w_rd0) p0.rdata <= i_data;
         if (w_rd1) p1.rdata <= i_data;
      end
   end
endmodule

// File: tb/tb_data_reg_arbiter.sv
// Directed bench for data_reg_arbiter with a behavioural 16x16 register file.
module tb_data_reg_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_data;
   logic [3:0]  lda;
   logic [15:0] din;
   logic [3:0]  raddr;
   logic [15:0] rd_data;
   logic        bd_we = 1'b0;
   logic [3:0]  bd_addr = '0;
   logic [15:0] bd_data = '0;
   logic [15:0] mem [16];
   int          n_cmp = 0;
   int          n_err = 0;
   int          gnt0_pat [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};

   data_reg_arbiter_if #(.AW(4), .DW(16)) if0 ();
   data_reg_arbiter_if #(.AW(4), .DW(16)) if1 ();

   data_reg_arbiter #(.AW(4), .DW(16), .MAX_LOCK(4)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .p0                  (if0),
      .p1                  (if1),
      .o_load_data         (load_data),
      .o_load_data_address (lda),
      .o_data_input        (din),
      .o_address           (raddr),
      .i_data              (rd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load_data) mem[lda] <= din;
      else if (bd_we) mem[bd_addr] <= bd_data;
   end
   assign rd_data = mem[raddr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_p0(input logic req, input logic we, input logic lock,
                         input logic [3:0] addr, input logic [15:0] wdata);
      if0.req = req; if0.we = we; if0.lock = lock; if0.addr = addr; if0.wdata = wdata;
   endtask

   task automatic set_p1(input logic req, input logic we, input logic lock,
                         input logic [3:0] addr, input logic [15:0] wdata);
      if1.req = req; if1.we = we; if1.lock = lock; if1.addr = addr; if1.wdata = wdata;
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      set_p0(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
      set_p1(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
      for (int i = 0; i < 16; i++) begin
         bd_we = 1'b1; bd_addr = 4'(i); bd_data = 16'h0;
         tick();
      end
      bd_addr = 4'd3; bd_data = 16'h00A5;
      tick();
      bd_we = 1'b0;

      // reset state, with a request present to prove grants are forced off
      set_p0(1'b1, 1'b1, 1'b0, 4'd2, 16'hBEEF);
      #1;
      check("rst_gnt0", if0.gnt, 0);
      check("rst_load_data", load_data, 0);
      check("rst_rvalid0", if0.rvalid, 0);
      check("rst_rdata0", if0.rdata, 0);
      set_p0(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // both read addr 3: port 0 first, port 1 next cycle
      set_p0(1'b1, 1'b0, 1'b0, 4'd3, 16'h0);
      set_p1(1'b1, 1'b0, 1'b0, 4'd3, 16'h0);
      #1;
      check("t1_gnt0", if0.gnt, 1);
      check("t1_gnt1", if1.gnt, 0);
      check("t1_address", raddr, 3);
      tick();
      check("t1_rvalid0", if0.rvalid, 1);
      check("t1_rdata0", if0.rdata, 16'h00A5);
      check("t1_rvalid1_early", if1.rvalid, 0);
      if0.req = 1'b0;
      #1;
      check("t1_gnt1_next", if1.gnt, 1);
      tick();
      check("t1_rvalid1", if1.rvalid, 1);
      check("t1_rdata1", if1.rdata, 16'h00A5);
      check("t1_rvalid0_off", if0.rvalid, 0);

      // both hold req without lock: alternate starting with port 0
      set_p0(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
      set_p1(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("t2_gnt0_c%0d", i), if0.gnt, (i % 2 == 0) ? 1 : 0);
         check($sformatf("t2_gnt1_c%0d", i), if1.gnt, (i % 2 == 1) ? 1 : 0);
         tick();
      end
      set_p0(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
      set_p1(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);

      // port 1 writes addr 7, port 0 reads it back the next cycle
      set_p1(1'b1, 1'b1, 1'b0, 4'd7, 16'h1234);
      #1;
      check("t3_gnt1", if1.gnt, 1);
      check("t3_load_data", load_data, 1);
      check("t3_wr_addr", lda, 7);
      check("t3_wr_data", din, 16'h1234);
      tick();
      set_p1(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
      set_p0(1'b1, 1'b0, 1'b0, 4'd7, 16'h0);
      #1;
      check("t3_gnt0", if0.gnt, 1);
      check("t3_rd_load_data", load_data, 0);
      tick();
      check("t3_rvalid0", if0.rvalid, 1);
      check("t3_rdata0", if0.rdata, 16'h1234);

      // port 0 locked against a continuous port 1: 4 grants then 1 rotation
      set_p0(1'b1, 1'b0, 1'b1, 4'd7, 16'h0);
      set_p1(1'b1, 1'b0, 1'b0, 4'd7, 16'h0);
      for (int i = 0; i < 10; i++) begin
         #1;
         check($sformatf("t4_gnt0_c%0d", i), if0.gnt, 32'(gnt0_pat[i]));
         check($sformatf("t4_gnt1_c%0d", i), if1.gnt, 32'(1 - gnt0_pat[i]));
         tick();
      end
      if1.req = 1'b0;
      for (int i = 0; i < 14; i++) begin
         #1;
         check($sformatf("t4_solo_gnt0_c%0d", i), if0.gnt, 1);
         tick();
      end
      if1.req = 1'b1;
      #1;
      check("t4_rotate_gnt1", if1.gnt, 1);
      check("t4_rotate_gnt0", if0.gnt, 0);
      tick();
      set_p0(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
      set_p1(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);

      // port 0 writes addr 15, then a granted read is cut off by reset
      set_p0(1'b1, 1'b1, 1'b0, 4'd15, 16'hFFFF);
      #1;
      check("t5_wr_gnt0", if0.gnt, 1);
      check("t5_wr_addr", lda, 15);
      tick();
      set_p0(1'b1, 1'b0, 1'b0, 4'd3, 16'h0);
      #1;
      check("t5_rd_gnt0", if0.gnt, 1);
      check("t5_rdata0_pre", if0.rdata, 16'h1234);
      rst_n = 1'b0;
      #1;
      check("t5_rst_gnt0", if0.gnt, 0);
      check("t5_rst_load_data", load_data, 0);
      check("t5_rst_rdata0", if0.rdata, 0);
      check("t5_rst_rvalid0", if0.rvalid, 0);
      tick();
      check("t5_rst_rvalid0_edge", if0.rvalid, 0);
      set_p0(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
      rst_n = 1'b1;
      tick();
      check("t5_post_rvalid0", if0.rvalid, 0);
      check("t5_post_rdata0", if0.rdata, 0);

      // fresh arbitration after release; addr 15 reads back without aliasing
      set_p0(1'b1, 1'b0, 1'b0, 4'd15, 16'h0);
      set_p1(1'b1, 1'b0, 1'b0, 4'd7, 16'h0);
      #1;
      check("t6_gnt0", if0.gnt, 1);
      check("t6_gnt1", if1.gnt, 0);
      check("t6_address", raddr, 15);
      tick();
      check("t6_rvalid0", if0.rvalid, 1);
      check("t6_rdata0", if0.rdata, 16'hFFFF);
      if0.req = 1'b0;
      #1;
      check("t6_gnt1_next", if1.gnt, 1);
      tick();
      check("t6_rvalid1", if1.rvalid, 1);
      check("t6_rdata1", if1.rdata, 16'h1234);
      set_p1(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
